// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates ALU and LSU writeback requests onto a single
// registered register-file write port and keeps a pending-write scoreboard
// that drives the decode stall.
// Optional feature macro: WB_RR_ARB_EN
//   defined   -> round-robin between ALU and LSU on contention
//   undefined -> fixed priority, LSU always wins over ALU
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_wd,
  output logic        alu_ready,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_wd,
  output logic        lsu_ready,
  input  logic        sb_set_valid,
  input  logic [4:0]  sb_set_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        stall,
  output logic [4:0]  a3,
  output logic [31:0] wd,
  output logic        wen,
  output logic [31:0] pend
);

  logic        xfer;
  logic [4:0]  xfer_rd;
  logic [31:0] xfer_wd;
  logic        xfer_wr;
  logic [31:0] pend_d;

`ifdef WB_RR_ARB_EN
  typedef enum logic {
    LAST_ALU = 1'b0,
    LAST_LSU = 1'b1
  } last_t;

  last_t last_q;
  last_t last_d;

  // Grant: lone requester wins outright; on contention the one not granted last wins
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!rst) begin
      if (alu_valid && lsu_valid) begin
        if (last_q == LAST_LSU) alu_ready = 1'b1;
        else                    lsu_ready = 1'b1;
      end else begin
        alu_ready = alu_valid;
        lsu_ready = lsu_valid;
      end
    end
  end

  // Pointer follows every transfer, contended or not
  always_comb begin
    last_d = last_q;
    if (alu_ready)      last_d = LAST_ALU;
    else if (lsu_ready) last_d = LAST_LSU;
  end

  // Pointer register; reset behaves as if the LSU was granted last
  always_ff @(posedge clk) begin
    if (rst) last_q <= LAST_LSU;
    else     last_q <= last_d;
  end
`else
  // Grant: fixed priority, LSU over ALU, nothing granted during reset
  always_comb begin
    lsu_ready = !rst && lsu_valid;
    alu_ready = !rst && alu_valid && !lsu_valid;
  end
`endif

  // Select the granted request; writes to x0 are accepted but never issued
  always_comb begin
    xfer    = alu_ready || lsu_ready;
    xfer_rd = lsu_ready ? lsu_rd : alu_rd;
    xfer_wd = lsu_ready ? lsu_wd : alu_wd;
    xfer_wr = xfer && (xfer_rd != '0);
  end

  // Registered write port; a3/wd hold their last values when no write issues
  always_ff @(posedge clk) begin
    if (rst) begin
      wen <= 1'b0;
      a3  <= '0;
      wd  <= '0;
    end else begin
      wen <= xfer_wr;
      if (xfer_wr) begin
        a3 <= xfer_rd;
        wd <= xfer_wd;
      end
    end
  end

  // Scoreboard next state: clear on the write cycle, then set so set wins
  always_comb begin
    pend_d = pend;
    if (wen)          pend_d[a3]        = 1'b0;
    if (sb_set_valid) pend_d[sb_set_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= pend_d;
  end

  // Stall on any pending source; no bypass of the write currently in flight
  always_comb begin
    stall = ((rs1 != '0) && pend[rs1]) || ((rs2 != '0) && pend[rs2]);
  end

endmodule
